// File: rtl/xbee_gbi_receiver.sv
// rtl/xbee_gbi_receiver.sv - 8N1 UART receiver with GBI frame ("GBI<d>-<T>-#") decoder.
// Optional MSB_FIRST_EN: shift data bits MSB first instead of standard UART LSB first.
module xbee_gbi_receiver #(
    parameter int CLKS_PER_BIT = 434,
    parameter int HALF_BIT     = 217
) (
    input  logic       clk_50M,
    input  logic       reset,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err,
    output logic       msg_valid,
    output logic [3:0] bin_number,
    output logic [1:0] colour,
    output logic       parse_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] C_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_HALF_LAST = CW'(HALF_BIT - 1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
    typedef enum logic [2:0] {P_G, P_B, P_I, P_DIGIT, P_DASH1, P_TYPE, P_DASH2, P_HASH} p_state_t;

    logic            r_rx_meta;
    logic            r_rx_sync;
    rx_state_t       r_rx_state;
    rx_state_t       w_rx_next;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            w_cnt_clr;
    logic            w_bit_tick;
    logic            w_stop_ok;
    logic            w_stop_bad;

    p_state_t        r_p_state;
    p_state_t        w_p_next;
    p_state_t        w_p_adv;
    logic            w_match;
    logic [3:0]      r_shadow_digit;
    logic [1:0]      r_shadow_colour;
    logic [1:0]      w_type_code;

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) r_rx_state <= RX_IDLE;
        else       r_rx_state <= w_rx_next;
    end

    always_comb begin
        w_rx_next  = r_rx_state;
        w_cnt_clr  = 1'b0;
        w_bit_tick = 1'b0;
        w_stop_ok  = 1'b0;
        w_stop_bad = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (!r_rx_sync) begin
                    w_rx_next = RX_START;
                    w_cnt_clr = 1'b1;
                end
            end
            RX_START: begin
                if (r_cnt == C_HALF_LAST) begin
                    w_cnt_clr = 1'b1;
                    w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (r_cnt == C_BIT_LAST) begin
                    w_cnt_clr  = 1'b1;
                    w_bit_tick = 1'b1;
                    if (r_bit_idx == 3'd7) w_rx_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (r_cnt == C_BIT_LAST) begin
                    w_cnt_clr = 1'b1;
                    if (r_rx_sync) begin
                        w_stop_ok = 1'b1;
                        w_rx_next = RX_IDLE;
                    end else begin
                        w_stop_bad = 1'b1;
                        w_rx_next  = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                // Held-low line must return high before a new start can be recognised
                if (r_rx_sync) w_rx_next = RX_IDLE;
            end
            default: w_rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'd0;
            rx_byte    <= 8'd0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= w_stop_ok;
            frame_err  <= w_stop_bad;
            if (w_cnt_clr || r_rx_state == RX_IDLE || r_rx_state == RX_BREAK)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
            if (w_bit_tick) begin
                r_bit_idx <= r_bit_idx + 3'd1;
`ifdef MSB_FIRST_EN
                r_shift   <= {r_shift[6:0], r_rx_sync};
`else
                r_shift   <= {r_rx_sync, r_shift[7:1]};
`endif
            end
            if (w_stop_ok) rx_byte <= r_shift;
        end
    end

    always_comb begin
        w_type_code = 2'b11;
        case (rx_byte)
            8'h4D:   w_type_code = 2'b00;
            8'h44:   w_type_code = 2'b01;
            8'h57:   w_type_code = 2'b10;
            default: w_type_code = 2'b11;
        endcase
    end

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) r_p_state <= P_G;
        else       r_p_state <= w_p_next;
    end

    always_comb begin
        w_p_next = r_p_state;
        w_match  = 1'b0;
        w_p_adv  = P_G;
        case (r_p_state)
            P_G:     begin w_match = (rx_byte == 8'h47); w_p_adv = P_B;     end
            P_B:     begin w_match = (rx_byte == 8'h42); w_p_adv = P_I;     end
            P_I:     begin w_match = (rx_byte == 8'h49); w_p_adv = P_DIGIT; end
            P_DIGIT: begin w_match = (rx_byte >= 8'h31) && (rx_byte <= 8'h39); w_p_adv = P_DASH1; end
            P_DASH1: begin w_match = (rx_byte == 8'h2D); w_p_adv = P_TYPE;  end
            P_TYPE:  begin w_match = (w_type_code != 2'b11); w_p_adv = P_DASH2; end
            P_DASH2: begin w_match = (rx_byte == 8'h2D); w_p_adv = P_HASH;  end
            P_HASH:  begin w_match = (rx_byte == 8'h23); w_p_adv = P_G;     end
            default: begin w_match = 1'b0;               w_p_adv = P_G;     end
        endcase
        if (frame_err)
            w_p_next = P_G;
        else if (byte_valid)
            w_p_next = w_match ? w_p_adv : ((rx_byte == 8'h47) ? P_B : P_G);
    end

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            r_shadow_digit  <= 4'd0;
            r_shadow_colour <= 2'd0;
            bin_number      <= 4'd0;
            colour          <= 2'd0;
            msg_valid       <= 1'b0;
            parse_err       <= 1'b0;
        end else begin
            msg_valid <= 1'b0;
            parse_err <= 1'b0;
            if (byte_valid && !frame_err) begin
                if (!w_match) begin
                    parse_err <= 1'b1;
                end else begin
                    if (r_p_state == P_DIGIT) r_shadow_digit  <= rx_byte[3:0];
                    if (r_p_state == P_TYPE)  r_shadow_colour <= w_type_code;
                    if (r_p_state == P_HASH) begin
                        bin_number <= r_shadow_digit;
                        colour     <= r_shadow_colour;
                        msg_valid  <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_xbee_gbi_receiver.sv
// tb/tb_xbee_gbi_receiver.sv - directed self-checking bench for xbee_gbi_receiver.
module tb_xbee_gbi_receiver;

    localparam int BIT  = 64;
    localparam int HALF = 32;

    logic       clk_50M = 1'b0;
    logic       reset   = 1'b1;
    logic       rx      = 1'b1;
    logic       byte_valid;
    logic [7:0] rx_byte;
    logic       frame_err;
    logic       msg_valid;
    logic [3:0] bin_number;
    logic [1:0] colour;
    logic       parse_err;

    int n_checks = 0;
    int n_fail   = 0;

    int n_bv = 0, n_mv = 0, n_fe = 0, n_pe = 0, n_mv_bad = 0;
    logic [7:0] got_bytes [0:63];
    logic [3:0] mv_bin    [0:15];
    logic [1:0] mv_col    [0:15];
    logic       prev_hash = 1'b0;

    xbee_gbi_receiver #(.CLKS_PER_BIT(BIT), .HALF_BIT(HALF)) dut (
        .clk_50M    (clk_50M),
        .reset      (reset),
        .rx         (rx),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .frame_err  (frame_err),
        .msg_valid  (msg_valid),
        .bin_number (bin_number),
        .colour     (colour),
        .parse_err  (parse_err)
    );

    always #10 clk_50M = ~clk_50M;

    always @(negedge clk_50M) begin
        if (byte_valid) begin
            got_bytes[n_bv % 64] = rx_byte;
            n_bv++;
        end
        if (msg_valid) begin
            mv_bin[n_mv % 16] = bin_number;
            mv_col[n_mv % 16] = colour;
            n_mv++;
            if (!prev_hash) n_mv_bad++;
        end
        if (frame_err) n_fe++;
        if (parse_err) n_pe++;
        prev_hash = byte_valid && (rx_byte == 8'h23);
    end

    task automatic send_byte(input logic [7:0] b, input int stop_low);
        @(negedge clk_50M) rx = 1'b0;
        repeat (BIT) @(negedge clk_50M);
        for (int i = 0; i < 8; i++) begin
`ifdef MSB_FIRST_EN
            rx = b[7-i];
`else
            rx = b[i];
`endif
            repeat (BIT) @(negedge clk_50M);
        end
        if (stop_low > 0) begin
            rx = 1'b0;
            repeat (stop_low) @(negedge clk_50M);
        end
        rx = 1'b1;
        repeat (BIT) @(negedge clk_50M);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 0);
        repeat (8) @(negedge clk_50M);
    endtask

    task automatic test_reset;
        repeat (5) @(negedge clk_50M);
        n_checks++;
        if ({byte_valid, rx_byte, frame_err, msg_valid, bin_number, colour, parse_err} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0",
                     {byte_valid, rx_byte, frame_err, msg_valid, bin_number, colour, parse_err});
        end
        reset = 1'b0;
        repeat (20) @(negedge clk_50M);
        n_checks++;
        if (n_bv + n_mv + n_fe + n_pe !== 0) begin
            n_fail++;
            $display("FAIL reset_idle_pulses: got %0d want 0", n_bv + n_mv + n_fe + n_pe);
        end
    endtask

    task automatic test_basic;
        int bv0, mv0, fe0, pe0;
        string s;
        logic [7:0] want;
        s = "GBI1-M-#";
        bv0 = n_bv; mv0 = n_mv; fe0 = n_fe; pe0 = n_pe;
        send_str(s);
        n_checks++;
        if (n_bv - bv0 !== 8) begin n_fail++; $display("FAIL basic_byte_count: got %0d want 8", n_bv - bv0); end
        for (int i = 0; i < 8; i++) begin
            want = s[i];
            n_checks++;
            if (got_bytes[(bv0 + i) % 64] !== want) begin
                n_fail++;
                $display("FAIL basic_byte%0d: got %h want %h", i, got_bytes[(bv0 + i) % 64], want);
            end
        end
        n_checks++;
        if (n_mv - mv0 !== 1) begin n_fail++; $display("FAIL basic_msg_count: got %0d want 1", n_mv - mv0); end
        n_checks++;
        if ({bin_number, colour} !== {4'd1, 2'b00}) begin
            n_fail++; $display("FAIL basic_outputs: got %0d/%b want 1/00", bin_number, colour);
        end
        n_checks++;
        if ((n_fe - fe0) + (n_pe - pe0) !== 0) begin
            n_fail++; $display("FAIL basic_errors: got fe=%0d pe=%0d want 0", n_fe - fe0, n_pe - pe0);
        end
    endtask

    task automatic test_back_to_back;
        int mv0;
        mv0 = n_mv;
        send_str("GBI9-W-#GBI4-D-#");
        n_checks++;
        if (n_mv - mv0 !== 2) begin n_fail++; $display("FAIL b2b_msg_count: got %0d want 2", n_mv - mv0); end
        n_checks++;
        if ({mv_bin[mv0 % 16], mv_col[mv0 % 16]} !== {4'd9, 2'b10}) begin
            n_fail++; $display("FAIL b2b_first: got %0d/%b want 9/10", mv_bin[mv0 % 16], mv_col[mv0 % 16]);
        end
        n_checks++;
        if ({mv_bin[(mv0 + 1) % 16], mv_col[(mv0 + 1) % 16]} !== {4'd4, 2'b01}) begin
            n_fail++;
            $display("FAIL b2b_second: got %0d/%b want 4/01", mv_bin[(mv0 + 1) % 16], mv_col[(mv0 + 1) % 16]);
        end
        n_checks++;
        if (n_mv_bad !== 0) begin n_fail++; $display("FAIL msg_valid_timing: got %0d misaligned want 0", n_mv_bad); end
    endtask

    task automatic test_parse_error;
        int mv0, pe0;
        mv0 = n_mv; pe0 = n_pe;
        send_str("GBX3-M-#");
        n_checks++;
        if (n_pe - pe0 !== 6) begin n_fail++; $display("FAIL parse_err_count: got %0d want 6", n_pe - pe0); end
        n_checks++;
        if (n_mv - mv0 !== 0) begin n_fail++; $display("FAIL parse_no_msg: got %0d want 0", n_mv - mv0); end
        n_checks++;
        if ({bin_number, colour} !== {4'd4, 2'b01}) begin
            n_fail++; $display("FAIL parse_hold: got %0d/%b want 4/01", bin_number, colour);
        end
        pe0 = n_pe;
        send_str("GBI3-M-#");
        n_checks++;
        if (n_mv - mv0 !== 1 || {bin_number, colour} !== {4'd3, 2'b00} || n_pe !== pe0) begin
            n_fail++;
            $display("FAIL parse_recover: got mv=%0d %0d/%b pe=%0d want 1 3/00 0",
                     n_mv - mv0, bin_number, colour, n_pe - pe0);
        end
    endtask

    task automatic test_glitch;
        int bv0, fe0, pe0;
        bv0 = n_bv; fe0 = n_fe; pe0 = n_pe;
        @(negedge clk_50M) rx = 1'b0;
        repeat (20) @(negedge clk_50M);
        rx = 1'b1;
        repeat (200) @(negedge clk_50M);
        n_checks++;
        if ((n_bv - bv0) + (n_fe - fe0) + (n_pe - pe0) !== 0) begin
            n_fail++;
            $display("FAIL glitch_pulses: got bv=%0d fe=%0d pe=%0d want 0", n_bv - bv0, n_fe - fe0, n_pe - pe0);
        end
        send_str("G");
        n_checks++;
        if (n_bv - bv0 !== 1 || got_bytes[bv0 % 64] !== 8'h47) begin
            n_fail++;
            $display("FAIL glitch_then_byte: got %0d bytes last %h want 1 47", n_bv - bv0, got_bytes[bv0 % 64]);
        end
    endtask

    task automatic test_frame_error;
        int bv0, fe0, pe0, mv0;
        bv0 = n_bv; fe0 = n_fe; pe0 = n_pe; mv0 = n_mv;
        send_byte(8'h47, 1000);
        repeat (20) @(negedge clk_50M);
        n_checks++;
        if (n_fe - fe0 !== 1) begin n_fail++; $display("FAIL frame_err_count: got %0d want 1", n_fe - fe0); end
        n_checks++;
        if (n_bv - bv0 !== 0 || n_pe - pe0 !== 0) begin
            n_fail++; $display("FAIL frame_err_side: got bv=%0d pe=%0d want 0", n_bv - bv0, n_pe - pe0);
        end
        send_str("GBI2-D-#");
        n_checks++;
        if (n_mv - mv0 !== 1 || {bin_number, colour} !== {4'd2, 2'b01}) begin
            n_fail++;
            $display("FAIL frame_err_recover: got mv=%0d %0d/%b want 1 2/01", n_mv - mv0, bin_number, colour);
        end
    endtask

    task automatic test_reset_mid_frame;
        int mv0;
        mv0 = n_mv;
        send_byte(8'h47, 0);
        send_byte(8'h42, 0);
        send_byte(8'h49, 0);
        send_byte(8'h35, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk_50M);
        n_checks++;
        if ({msg_valid, bin_number, colour} !== 7'd0) begin
            n_fail++; $display("FAIL midreset_outputs: got %0d/%b want 0/00", bin_number, colour);
        end
        reset = 1'b0;
        send_str("-W-#");
        n_checks++;
        if (n_mv - mv0 !== 0 || {bin_number, colour} !== {4'd0, 2'b00}) begin
            n_fail++;
            $display("FAIL midreset_tail: got mv=%0d %0d/%b want 0 0/00", n_mv - mv0, bin_number, colour);
        end
        send_str("GBI7-W-#");
        n_checks++;
        if (n_mv - mv0 !== 1 || {bin_number, colour} !== {4'd7, 2'b10}) begin
            n_fail++;
            $display("FAIL midreset_recover: got mv=%0d %0d/%b want 1 7/10", n_mv - mv0, bin_number, colour);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_parse_error();
        test_glitch();
        test_frame_error();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
